// File: rtl/cordic_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_issue_ctrl
// Purpose  : Host-side issue controller for a CORDIC sin/cos custom
//            instruction unit. Buffers host requests in a 2-entry FIFO,
//            issues one operation at a time over a start/done handshake,
//            buffers results in a 2-entry FIFO and recovers a hung unit
//            with a timeout abort plus a one-cycle unit reset.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic        req_cos,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic        cu_clk_en,
  output logic        cu_reset,
  output logic        cu_start,
  output logic [31:0] cu_dataa,
  output logic [31:0] cu_datab,
  output logic        cu_cos,
  input  logic        cu_done,
  input  logic [31:0] cu_result
);

  // Quiet NaN returned to the host when an operation is aborted.
  localparam logic [31:0] c_QNAN = 32'h7FC0_0000;
  // Wait-counter value at which the in-flight operation is abandoned.
  localparam logic [7:0]  c_TMO  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  r_err_count;
  logic        r_cu_start;
  logic [31:0] r_cu_dataa;
  logic        r_cu_cos;

  // Request FIFO storage: {cos select, angle}.
  logic [32:0] r_req_mem [2];
  logic        r_req_wr;
  logic        r_req_rd;
  logic [1:0]  r_req_cnt;

  // Response FIFO storage: {timeout flag, result}.
  logic [32:0] r_rsp_mem [2];
  logic        r_rsp_wr;
  logic        r_rsp_rd;
  logic [1:0]  r_rsp_cnt;

  logic        w_req_push;
  logic        w_timeout;
  logic        w_complete;
  logic        w_rsp_pop;
  logic [32:0] w_rsp_entry;

  assign w_req_push  = req_valid & req_ready;
  assign w_rsp_pop   = rsp_valid & rsp_ready;
  assign w_timeout   = (r_state == S_WAIT) && (r_wait_cnt == c_TMO);
  // A completion (real or aborted) retires the request head and pushes a response.
  assign w_complete  = (r_state == S_WAIT) && (cu_done || (r_wait_cnt == c_TMO));
  // A done arriving in the timeout cycle takes priority over the abort.
  assign w_rsp_entry = cu_done ? {1'b0, cu_result} : {1'b1, c_QNAN};

  assign req_ready   = (r_req_cnt != 2'd2);
  assign rsp_valid   = (r_rsp_cnt != 2'd0);
  assign rsp_data    = r_rsp_mem[r_rsp_rd][31:0];
  assign rsp_timeout = r_rsp_mem[r_rsp_rd][32];
  assign err_count   = r_err_count;
  assign busy        = (r_state != S_IDLE) || (r_req_cnt != 2'd0) || (r_rsp_cnt != 2'd0);
  assign cu_clk_en   = rst_n;
  assign cu_reset    = (r_state == S_FLUSH) || !rst_n;
  assign cu_start    = r_cu_start;
  assign cu_dataa    = r_cu_dataa;
  assign cu_datab    = 32'd0;
  assign cu_cos      = r_cu_cos;

  // Request FIFO: host pushes, completion of the in-flight operation pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_mem[0] <= '0;
      r_req_mem[1] <= '0;
      r_req_wr     <= 1'b0;
      r_req_rd     <= 1'b0;
      r_req_cnt    <= 2'd0;
    end else begin
      if (w_req_push) begin
        r_req_mem[r_req_wr] <= {req_cos, req_data};
        r_req_wr            <= ~r_req_wr;
      end
      if (w_complete) begin
        r_req_rd <= ~r_req_rd;
      end
      case ({w_req_push, w_complete})
        2'b10:   r_req_cnt <= r_req_cnt + 2'd1;
        2'b01:   r_req_cnt <= r_req_cnt - 2'd1;
        default: r_req_cnt <= r_req_cnt;
      endcase
    end
  end

  // Response FIFO: completion pushes, host pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_mem[0] <= '0;
      r_rsp_mem[1] <= '0;
      r_rsp_wr     <= 1'b0;
      r_rsp_rd     <= 1'b0;
      r_rsp_cnt    <= 2'd0;
    end else begin
      if (w_complete) begin
        r_rsp_mem[r_rsp_wr] <= w_rsp_entry;
        r_rsp_wr            <= ~r_rsp_wr;
      end
      if (w_rsp_pop) begin
        r_rsp_rd <= ~r_rsp_rd;
      end
      case ({w_complete, w_rsp_pop})
        2'b10:   r_rsp_cnt <= r_rsp_cnt + 2'd1;
        2'b01:   r_rsp_cnt <= r_rsp_cnt - 2'd1;
        default: r_rsp_cnt <= r_rsp_cnt;
      endcase
    end
  end

  // Issue FSM: load operands, pulse start, wait for done or abort, flush unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      r_err_count <= 8'd0;
      r_cu_start  <= 1'b0;
      r_cu_dataa  <= 32'd0;
      r_cu_cos    <= 1'b0;
    end else begin
      r_cu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Only issue when the response is guaranteed a free slot.
          if ((r_req_cnt != 2'd0) && (r_rsp_cnt != 2'd2)) begin
            r_cu_dataa <= r_req_mem[r_req_rd][31:0];
            r_cu_cos   <= r_req_mem[r_req_rd][32];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cu_start <= 1'b1;
          r_wait_cnt <= 8'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cu_done) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
            r_state <= S_FLUSH;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_FLUSH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_issue_ctrl
// Purpose  : Directed self-checking bench for cordic_issue_ctrl. Instance
//            a uses the default TIMEOUT, instance b uses TIMEOUT = 16; both
//            share all inputs and each scenario checks the relevant one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_issue_ctrl;

  localparam logic [31:0] K = 32'h0F0F_0F0F;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_cos;
  logic        rsp_ready;
  logic        cu_done;
  logic [31:0] cu_result;

  logic        a_req_ready, a_rsp_valid, a_rsp_timeout, a_busy, a_cu_clk_en, a_cu_reset, a_cu_start, a_cu_cos;
  logic [31:0] a_rsp_data, a_cu_dataa, a_cu_datab;
  logic [7:0]  a_err_count;
  logic        b_req_ready, b_rsp_valid, b_rsp_timeout, b_busy, b_cu_clk_en, b_cu_reset, b_cu_start, b_cu_cos;
  logic [31:0] b_rsp_data, b_cu_dataa, b_cu_datab;
  logic [7:0]  b_err_count;

  int checks = 0;
  int errors = 0;
  int a_starts = 0;
  int b_starts = 0;

  bit          model_en = 1'b0;
  bit          model_sel16 = 1'b0;
  bit          model_fix = 1'b0;
  logic [31:0] model_fix_val = 32'd0;
  int          model_lat = 4;

  cordic_issue_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_data(req_data), .req_cos(req_cos),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_timeout(a_rsp_timeout),
    .err_count(a_err_count), .busy(a_busy), .cu_clk_en(a_cu_clk_en), .cu_reset(a_cu_reset),
    .cu_start(a_cu_start), .cu_dataa(a_cu_dataa), .cu_datab(a_cu_datab), .cu_cos(a_cu_cos),
    .cu_done(cu_done), .cu_result(cu_result)
  );

  cordic_issue_ctrl #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_data(req_data), .req_cos(req_cos),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_timeout(b_rsp_timeout),
    .err_count(b_err_count), .busy(b_busy), .cu_clk_en(b_cu_clk_en), .cu_reset(b_cu_reset),
    .cu_start(b_cu_start), .cu_dataa(b_cu_dataa), .cu_datab(b_cu_datab), .cu_cos(b_cu_cos),
    .cu_done(cu_done), .cu_result(cu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start-pulse monitor for both instances.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (a_cu_start === 1'b1) a_starts++;
      if (b_cu_start === 1'b1) b_starts++;
    end
  end

  // Unit model: done model_lat cycles after the start cycle.
  initial begin
    int          r;
    bit          act;
    logic [31:0] cap;
    r = 0; act = 1'b0; cap = 32'd0;
    forever begin
      @(posedge clk); #2;
      if (model_en) begin
        cu_done = 1'b0;
        if (model_sel16 ? b_cu_start : a_cu_start) begin
          r   = model_lat;
          act = 1'b1;
          cap = model_sel16 ? b_cu_dataa : a_cu_dataa;
        end else if (act) begin
          r = r - 1;
        end
        if (act && r == 0) begin
          cu_done   = 1'b1;
          cu_result = model_fix ? model_fix_val : (cap ^ K);
          act       = 1'b0;
        end
      end else begin
        act = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    model_en  = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    cu_done   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    a_starts = 0;
    b_starts = 0;
  endtask

  task automatic push(input logic [31:0] d, input logic c, input bit sel16);
    int n;
    req_valid = 1'b1;
    req_data  = d;
    req_cos   = c;
    n = 0;
    while (!(sel16 ? b_req_ready : a_req_ready) && n < 200) begin
      tick();
      n++;
    end
    if (!(sel16 ? b_req_ready : a_req_ready)) begin
      checks++; errors++;
      $display("FAIL push_wait: req_ready=0 after %0d cycles, required 1", n);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; cu_done = 1'b0;
    req_data = 32'd0; req_cos = 1'b0; cu_result = 32'd0;
    #3;
    checks++;
    if ({a_req_ready, a_cu_reset, a_cu_clk_en, a_rsp_valid, a_busy, a_cu_start, a_cu_cos, a_rsp_timeout} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 11000000",
               {a_req_ready, a_cu_reset, a_cu_clk_en, a_rsp_valid, a_busy, a_cu_start, a_cu_cos, a_rsp_timeout});
    end
    checks++;
    if ({a_cu_dataa, a_cu_datab, a_rsp_data, a_err_count} !== 104'd0) begin
      errors++;
      $display("FAIL reset_data: dataa=%h datab=%h rsp=%h err=%0d required all 0", a_cu_dataa, a_cu_datab, a_rsp_data, a_err_count);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({a_cu_reset, a_cu_clk_en, a_busy, b_cu_reset, b_cu_clk_en} !== 5'b01001) begin
      errors++;
      $display("FAIL reset_release: got %b required 01001", {a_cu_reset, a_cu_clk_en, a_busy, b_cu_reset, b_cu_clk_en});
    end
  endtask

  task automatic test_single;
    do_reset();
    model_sel16 = 1'b0; model_lat = 18; model_fix = 1'b1; model_fix_val = 32'h3F0A_5140; model_en = 1'b1;
    push(32'h3F80_0000, 1'b1, 1'b0);
    tick();
    checks++;
    if (a_cu_start !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_early: cu_start=%b busy=%b required 0/1", a_cu_start, a_busy);
    end
    tick();
    checks++;
    if (a_cu_start !== 1'b1 || a_cu_dataa !== 32'h3F80_0000 || a_cu_cos !== 1'b1) begin
      errors++;
      $display("FAIL single_start: start=%b dataa=%h cos=%b required 1/3f800000/1", a_cu_start, a_cu_dataa, a_cu_cos);
    end
    repeat (18) tick();
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_not_yet: rsp_valid=%b required 0", a_rsp_valid);
    end
    tick();
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h3F0A_5140 || a_rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b data=%h to=%b required 1/3f0a5140/0", a_rsp_valid, a_rsp_data, a_rsp_timeout);
    end
    repeat (5) tick();
    checks++;
    if (a_starts !== 1) begin
      errors++;
      $display("FAIL single_start_count: starts=%0d required 1", a_starts);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: rsp_valid=%b busy=%b required 0/0", a_rsp_valid, a_busy);
    end
    model_en = 1'b0; cu_done = 1'b0; model_fix = 1'b0;
  endtask

  task automatic test_back_pressure;
    logic [31:0] d [4];
    logic [31:0] got [3];
    int n;
    d[0] = 32'h3F00_0000; d[1] = 32'h3F40_0000; d[2] = 32'hBF80_0000; d[3] = 32'h4049_0FDB;
    do_reset();
    model_sel16 = 1'b0; model_lat = 4; model_fix = 1'b0; model_en = 1'b1;
    for (int i = 0; i < 4; i++) push(d[i], 1'(i % 2), 1'b0);
    checks++;
    if (a_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready: req_ready=%b required 0", a_req_ready);
    end
    repeat (30) tick();
    checks++;
    if (a_starts !== 2 || a_req_ready !== 1'b0 || a_rsp_data !== (d[0] ^ K)) begin
      errors++;
      $display("FAIL bp_stall: starts=%0d ready=%b head=%h required 2/0/%h", a_starts, a_req_ready, a_rsp_data, d[0] ^ K);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (a_rsp_data !== (d[1] ^ K)) begin
      errors++;
      $display("FAIL bp_second_head: head=%h required %h", a_rsp_data, d[1] ^ K);
    end
    n = 0;
    while (a_starts < 3 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (a_starts !== 3) begin
      errors++;
      $display("FAIL bp_third_start: starts=%0d required 3", a_starts);
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      if (a_rsp_valid) begin
        got[n] = a_rsp_data;
        n++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d responses required 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== (d[i+1] ^ K)) begin
          errors++;
          $display("FAIL bp_drain_%0d: data=%h required %h", i, got[i], d[i+1] ^ K);
        end
      end
    end
    model_en = 1'b0; cu_done = 1'b0;
  endtask

  task automatic test_timeout;
    do_reset();
    push(32'h4000_0000, 1'b0, 1'b1);
    push(32'h4040_0000, 1'b1, 1'b1);
    tick();
    checks++;
    if (b_cu_start !== 1'b1 || b_cu_dataa !== 32'h4000_0000) begin
      errors++;
      $display("FAIL to_start: start=%b dataa=%h required 1/40000000", b_cu_start, b_cu_dataa);
    end
    repeat (16) tick();
    checks++;
    if (b_rsp_valid !== 1'b0 || b_cu_reset !== 1'b0) begin
      errors++;
      $display("FAIL to_early: rsp_valid=%b cu_reset=%b required 0/0", b_rsp_valid, b_cu_reset);
    end
    tick();
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h7FC0_0000 || b_rsp_timeout !== 1'b1 ||
        b_err_count !== 8'd1 || b_cu_reset !== 1'b1) begin
      errors++;
      $display("FAIL to_abort: valid=%b data=%h to=%b err=%0d cu_reset=%b required 1/7fc00000/1/1/1",
               b_rsp_valid, b_rsp_data, b_rsp_timeout, b_err_count, b_cu_reset);
    end
    tick();
    checks++;
    if (b_cu_reset !== 1'b0) begin
      errors++;
      $display("FAIL to_reset_width: cu_reset=%b required 0", b_cu_reset);
    end
    model_sel16 = 1'b1; model_lat = 3; model_fix = 1'b0; model_en = 1'b1;
    repeat (2) tick();
    checks++;
    if (b_cu_start !== 1'b1 || b_cu_dataa !== 32'h4040_0000 || b_cu_cos !== 1'b1) begin
      errors++;
      $display("FAIL to_next_issue: start=%b dataa=%h cos=%b required 1/40400000/1", b_cu_start, b_cu_dataa, b_cu_cos);
    end
    repeat (4) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_data !== (32'h4040_0000 ^ K) || b_rsp_timeout !== 1'b0 || b_err_count !== 8'd1) begin
      errors++;
      $display("FAIL to_next_rsp: valid=%b data=%h to=%b err=%0d required 1/%h/0/1",
               b_rsp_valid, b_rsp_data, b_rsp_timeout, b_err_count, 32'h4040_0000 ^ K);
    end
    model_en = 1'b0; cu_done = 1'b0;
  endtask

  task automatic test_race;
    bit seen;
    do_reset();
    model_sel16 = 1'b1; model_lat = 16; model_fix = 1'b0; model_en = 1'b1;
    push(32'h3E80_0000, 1'b0, 1'b1);
    repeat (2) tick();
    checks++;
    if (b_cu_start !== 1'b1) begin
      errors++;
      $display("FAIL race_start: cu_start=%b required 1", b_cu_start);
    end
    repeat (16) tick();
    tick();
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_timeout !== 1'b0 || b_rsp_data !== (32'h3E80_0000 ^ K) || b_err_count !== 8'd0) begin
      errors++;
      $display("FAIL race_rsp: valid=%b to=%b data=%h err=%0d required 1/0/%h/0",
               b_rsp_valid, b_rsp_timeout, b_rsp_data, b_err_count, 32'h3E80_0000 ^ K);
    end
    seen = b_cu_reset;
    repeat (3) begin
      tick();
      seen = seen | b_cu_reset;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL race_no_flush: cu_reset seen=%b required 0", seen);
    end
    model_en = 1'b0; cu_done = 1'b0;
  endtask

  task automatic test_spurious;
    do_reset();
    cu_done   = 1'b1;
    cu_result = 32'hDEAD_BEEF;
    tick();
    cu_done = 1'b0;
    repeat (2) tick();
    checks++;
    if ({a_rsp_valid, a_busy, b_rsp_valid, b_busy, a_cu_start} !== 5'b0) begin
      errors++;
      $display("FAIL spurious_done: a_valid=%b a_busy=%b b_valid=%b b_busy=%b start=%b required all 0",
               a_rsp_valid, a_busy, b_rsp_valid, b_busy, a_cu_start);
    end
  endtask

  task automatic test_async_reset;
    bit stale;
    do_reset();
    push(32'h3F00_0000, 1'b0, 1'b0);
    push(32'h3F40_0000, 1'b1, 1'b0);
    tick();
    checks++;
    if (a_cu_start !== 1'b1) begin
      errors++;
      $display("FAIL ar_start: cu_start=%b required 1", a_cu_start);
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_req_ready, a_cu_reset, a_cu_clk_en, a_rsp_valid, a_busy, a_cu_start, a_cu_cos} !== 7'b1100000 ||
        a_cu_dataa !== 32'd0 || a_err_count !== 8'd0) begin
      errors++;
      $display("FAIL ar_reset_values: flags=%b dataa=%h err=%0d required 1100000/0/0",
               {a_req_ready, a_cu_reset, a_cu_clk_en, a_rsp_valid, a_busy, a_cu_start, a_cu_cos}, a_cu_dataa, a_err_count);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      tick();
      stale = stale | a_cu_start | a_rsp_valid | a_busy;
    end
    checks++;
    if (stale !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_stale: activity=%b req_ready=%b required 0/1", stale, a_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_timeout();
    test_race();
    test_spurious();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
